mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port of the multicycle MIPS core between
//  the CPU (fetch and load/store, selected upstream by i_or_d) and a program-loader/debug port.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter_sat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } arb_owner_t;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT_CYC  = 64;

  // Loader wins when the CPU is idle, or when the loader has waited long enough.
  function automatic logic pick_ldr(input logic cpu_req, input logic ldr_req,
                                    input logic starved);
    return ldr_req & (~cpu_req | starved);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Count up to MAX and hold there until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between the CPU and a loader/debug port.
// Each access runs IDLE -> BUSY (mem_req high) -> RESP (one-cycle ack).
// CPU has fixed priority; the loader overrides it after STARVE_LIMIT waiting cycles.
// Optional feature macro ARB_TIMEOUT_EN: aborts a BUSY phase after TIMEOUT_CYC cycles
// without mem_ready, acking the owner with err=1 and all-ones read data. The
// TIMEOUT_CYC parameter only exists when that macro is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
`ifdef ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
`endif
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t          state_r;
  arb_state_t          next_state_s;
  arb_owner_t          owner_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                cpu_ack_r;
  logic                ldr_ack_r;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic [DATA_W-1:0]   ldr_rdata_r;
  logic [DATA_W-1:0]   done_data_s;
  logic                grant_s;
  logic                grant_ldr_s;
  logic                done_s;
  logic                timeout_s;
  logic                starved_s;
  logic                starve_inc_s;
  logic [SW-1:0]       starve_cnt_s;
  logic                mem_req_s;
  logic                mem_we_s;

  assign grant_s     = (state_r == ARB_IDLE) & (cpu_req | ldr_req);
  assign grant_ldr_s = (state_r == ARB_IDLE) & pick_ldr(cpu_req, ldr_req, starved_s);
  assign done_s      = (state_r == ARB_BUSY) & (mem_ready | timeout_s);

  // The loader is not starving while it owns an in-flight access or is being granted now.
  assign starve_inc_s = ldr_req & ~grant_ldr_s &
                        ~((state_r != ARB_IDLE) & (owner_r == OWN_LDR));
  assign starved_s    = (starve_cnt_s == STARVE_MAX);

  sat_counter #(.MAX(STARVE_LIMIT), .W(SW)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (grant_ldr_s),
    .inc   (starve_inc_s),
    .count (starve_cnt_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic          to_inc_s;
  logic [TW-1:0] to_cnt_s;
  logic          err_r;

  // Counter holds the number of completed BUSY cycles of the current access.
  assign to_inc_s  = (state_r == ARB_BUSY) & ~mem_ready;
  assign timeout_s = (state_r == ARB_BUSY) & ~mem_ready & (to_cnt_s == TO_LAST);

  sat_counter #(.MAX(TIMEOUT_CYC), .W(TW)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (grant_s),
    .inc   (to_inc_s),
    .count (to_cnt_s)
  );

  // Error flag accompanies the ack of an aborted access.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: new requests are only considered in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (cpu_req | ldr_req) begin
          next_state_s = ARB_BUSY;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (mem_ready | timeout_s) begin
          next_state_s = ARB_RESP;
        end else begin
          next_state_s = ARB_BUSY;
        end
      end
      ARB_RESP: next_state_s = ARB_IDLE;
      default:  next_state_s = ARB_IDLE;
    endcase
  end

  // Memory strobes are decoded from the state register only.
  always_comb begin
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
    case (state_r)
      ARB_BUSY: begin
        mem_req_s = 1'b1;
        mem_we_s  = we_r;
      end
      default: begin
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // Data returned to the owner: all-ones on abort, zero for writes, memory data for reads.
  always_comb begin
    done_data_s = {DATA_W{1'b0}};
    if (timeout_s) begin
      done_data_s = {DATA_W{1'b1}};
    end else if (we_r) begin
      done_data_s = {DATA_W{1'b0}};
    end else begin
      done_data_s = mem_rdata;
    end
  end

  // Request latching at grant and response capture at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= OWN_CPU;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      cpu_ack_r   <= 1'b0;
      ldr_ack_r   <= 1'b0;
      cpu_rdata_r <= {DATA_W{1'b0}};
      ldr_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (grant_s) begin
        owner_r <= grant_ldr_s ? OWN_LDR : OWN_CPU;
        we_r    <= grant_ldr_s ? ldr_we : cpu_we;
        addr_r  <= grant_ldr_s ? ldr_addr : cpu_addr;
        wdata_r <= grant_ldr_s ? ldr_wdata : cpu_wdata;
      end else begin
        owner_r <= owner_r;
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      cpu_ack_r <= done_s & (owner_r == OWN_CPU);
      ldr_ack_r <= done_s & (owner_r == OWN_LDR);
      if (done_s && (owner_r == OWN_CPU)) begin
        cpu_rdata_r <= done_data_s;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
      if (done_s && (owner_r == OWN_LDR)) begin
        ldr_rdata_r <= done_data_s;
      end else begin
        ldr_rdata_r <= ldr_rdata_r;
      end
    end
  end

  assign mem_req   = mem_req_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign ldr_ack   = ldr_ack_r;
  assign cpu_rdata = cpu_rdata_r;
  assign ldr_rdata = ldr_rdata_r;
  assign cpu_wait  = cpu_req & ~cpu_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks, a monitor
// pops and compares them whenever an ack appears. Honours ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_wait;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = 32'h0, ldr_wdata = 32'h0;
  logic [31:0] ldr_rdata;
  logic        ldr_ack;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model controls
  int mem_waits = 0;
  bit mem_hang  = 1'b0;
  int busy_cnt  = 0;

  typedef struct {
    bit          is_ldr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
`ifdef ARB_TIMEOUT_EN
    .TIMEOUT_CYC(8),
`endif
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit is_ldr, input logic [31:0] rdata, input bit e);
    exp_t x;
    x.is_ldr = is_ldr;
    x.rdata  = rdata;
    x.err    = e;
    return x;
  endfunction

  // memory model: ready after mem_waits BUSY cycles, never when hung
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        busy_cnt++;
        mem_ready = !mem_hang && (busy_cnt > mem_waits);
      end else begin
        busy_cnt  = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // monitor: every ack must match the oldest expected completion
  always @(negedge clk) begin
    if (cpu_ack && ldr_ack) begin
      check("dual_ack", 1'b1, 1'b0);
    end else if (cpu_ack || ldr_ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {ldr_ack, cpu_ack}, 2'b00);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_port", ldr_ack, e.is_ldr);
        check("ack_rdata", ldr_ack ? ldr_rdata : cpu_rdata, e.rdata);
        check("ack_err", err, e.err);
      end
    end
  end

  // global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, nack, nacc;
    bit prev_req;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_acks", {cpu_ack, ldr_ack, err}, 3'b000);
    check("rst_data", {cpu_rdata, mem_addr}, 64'h0);
    check("rst_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: CPU read, zero-wait memory
    mem_waits = 0; mem_rdata = 32'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    sb_q.push_back(mk(1'b0, 32'h1234, 1'b0));
    @(negedge clk);
    check("t1_c0_mem_req", mem_req, 1'b0);
    check("t1_c0_wait", cpu_wait, 1'b1);
    @(negedge clk);
    check("t1_c1_mem", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
    check("t1_c1_wait", cpu_wait, 1'b1);
    @(negedge clk);
    check("t1_c2_ack", {cpu_ack, cpu_wait, mem_req}, 3'b100);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t1_c3_ack_low", cpu_ack, 1'b0);

    // 2: loader write, 3 wait states
    @(posedge clk); #1;
    mem_waits = 3;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h80; ldr_wdata = 32'hCAFE;
    sb_q.push_back(mk(1'b1, 32'h0, 1'b0));
    nbusy = 0; nack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin
        nbusy++;
        check("t2_stable", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h80, 32'hCAFE});
      end
      if (ldr_ack) begin
        nack++;
        ldr_req = 1'b0; ldr_we = 1'b0;
      end
    end
    check("t2_busy_cycles", nbusy, 4);
    check("t2_ack_count", nack, 1);

    // 3: both held, 1 wait state -> grants C, L, C, L
    @(posedge clk); #1;
    mem_waits = 1; mem_rdata = 32'h5A5A;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
    sb_q.push_back(mk(1'b0, 32'h5A5A, 1'b0));
    sb_q.push_back(mk(1'b1, 32'h5A5A, 1'b0));
    sb_q.push_back(mk(1'b0, 32'h5A5A, 1'b0));
    sb_q.push_back(mk(1'b1, 32'h5A5A, 1'b0));
    nack = 0;
    for (int i = 0; i < 60 && nack < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) nack++;
      if (nack == 4) begin
        cpu_req = 1'b0; ldr_req = 1'b0;
      end
    end
    check("t3_acks", nack, 4);
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_idle", mem_req, 1'b0);

    // 4: reset in BUSY aborts silently
    @(posedge clk); #1;
    mem_hang = 1'b1; mem_waits = 0;
    cpu_req = 1'b1; cpu_addr = 32'h100;
    nbusy = 0;
    for (int i = 0; i < 5 && nbusy == 0; i++) begin
      @(negedge clk);
      if (mem_req) nbusy++;
    end
    check("t4_busy_seen", nbusy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; mem_hang = 1'b0;
    @(negedge clk);
    check("t4_mem_req_low", mem_req, 1'b0);
    check("t4_no_ack", {cpu_ack, ldr_ack}, 2'b00);
    check("t4_cleared", {cpu_rdata, mem_addr}, 64'h0);
    @(posedge clk); #1;
    mem_rdata = 32'h77; cpu_addr = 32'h44; cpu_req = 1'b1;
    sb_q.push_back(mk(1'b0, 32'h77, 1'b0));
    nack = 0;
    for (int i = 0; i < 10 && nack == 0; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        nack++;
        cpu_req = 1'b0;
      end
    end
    check("t4_fresh_ack", nack, 1);

    // 5: CPU write dropped in BUSY still completes once
    @(posedge clk); #1;
    mem_waits = 2;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hBEEF;
    sb_q.push_back(mk(1'b0, 32'h0, 1'b0));
    nack = 0; nacc = 0; prev_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) nacc++;
      if (mem_req) cpu_req = 1'b0;
      prev_req = mem_req;
      if (cpu_ack) nack++;
    end
    check("t5_ack_once", nack, 1);
    check("t5_one_access", nacc, 1);
    cpu_we = 1'b0;

    // 6: memory never ready
    @(posedge clk); #1;
    mem_hang = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
`ifdef ARB_TIMEOUT_EN
    sb_q.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b1));
    nbusy = 0; nack = 0;
    for (int i = 0; i < 30 && nack == 0; i++) begin
      @(negedge clk);
      if (mem_req) nbusy++;
      if (cpu_ack) begin
        nack++;
        check("t6_err_with_ack", err, 1'b1);
        cpu_req = 1'b0;
      end
    end
    check("t6_busy_cycles", nbusy, 8);
    check("t6_ack", nack, 1);
    mem_hang = 1'b0;
`else
    nack = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) nack++;
    end
    check("t6_still_busy", mem_req, 1'b1);
    check("t6_no_ack", nack, 0);
    check("t6_err_tied", err, 1'b0);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; mem_hang = 1'b0;
    @(negedge clk);
    check("t6_recovered", mem_req, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
